// File: rtl/fpu_round_pkg.sv
// rtl/fpu_round_pkg.sv - rounding-mode encodings, round-bit rule and saturation constants
// Shared by round_pipe and round_incr; constants are width-generic so any MW/EW works.
package fpu_round_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RUP = 3'b010,
      RM_RDN = 3'b011,
      RM_RMM = 3'b100
   } rmode_e;

   // Reserved encodings collapse to RNE so later stages only ever see legal modes.
   function automatic logic [2:0] norm_rmode(input logic [2:0] rm);
      logic [2:0] r;
      r = (rm > RM_RMM) ? RM_RNE : rm;
      return r;
   endfunction

   function automatic logic rnd_bit(input logic [2:0] rm, input logic s, input logic l,
                                    input logic g, input logic t);
      logic r;
      case (rm)
         RM_RTZ:  r = 1'b0;
         RM_RUP:  r = ~s & (g | t);
         RM_RDN:  r = s & (g | t);
         RM_RMM:  r = g;
         default: r = g & (t | l);
      endcase
      return r;
   endfunction

   // On exponent overflow: 1 -> infinity, 0 -> largest finite magnitude.
   function automatic logic sat_to_inf(input logic [2:0] rm, input logic s);
      logic r;
      case (rm)
         RM_RTZ:  r = 1'b0;
         RM_RUP:  r = ~s;
         RM_RDN:  r = s;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] exp_inf(input int ew);
      return (64'd1 << ew) - 64'd1;
   endfunction

   function automatic logic [63:0] exp_max_finite(input int ew);
      return (64'd1 << ew) - 64'd2;
   endfunction

   function automatic logic [63:0] mant_max_finite(input int mw);
      return (64'd1 << (mw + 1)) - 64'd1;
   endfunction

endpackage

// File: rtl/round_incr.sv
// rtl/round_incr.sv - stage-B combinational increment, carry renormalise and overflow saturate
module round_incr
   import fpu_round_pkg::*;
#(
   parameter int MW = 23,
   parameter int EW = 8
) (
   input  logic          sign_i,
   input  logic [EW-1:0] exp_i,
   input  logic [MW:0]   mant_i,
   input  logic [2:0]    rmode_i,
   input  logic          rnd_i,
   input  logic          inexact_i,
   output logic [EW-1:0] exp_o,
   output logic [MW:0]   mant_o,
   output logic          inexact_o,
   output logic          overflow_o
);

   localparam logic [EW-1:0] EXP_INF  = EW'(exp_inf(EW));
   localparam logic [EW-1:0] EXP_MAXF = EW'(exp_max_finite(EW));
   localparam logic [MW:0]   MANT_MAXF = (MW+1)'(mant_max_finite(MW));

   logic [MW+1:0] sum;
   logic [EW-1:0] exp_inc;

   always_comb begin
      sum        = {1'b0, mant_i} + {{(MW+1){1'b0}}, rnd_i};
      exp_inc    = exp_i + 1'b1;
      exp_o      = exp_i;
      mant_o     = sum[MW:0];
      inexact_o  = inexact_i;
      overflow_o = 1'b0;
      if (exp_i == EXP_INF) begin
         // Inf/NaN operands pass through untouched and never raise flags.
         mant_o    = mant_i;
         inexact_o = 1'b0;
      end else if (sum[MW+1]) begin
         if (exp_inc == EXP_INF) begin
            overflow_o = 1'b1;
            inexact_o  = 1'b1;
            if (sat_to_inf(rmode_i, sign_i)) begin
               exp_o  = EXP_INF;
               mant_o = '0;
            end else begin
               exp_o  = EXP_MAXF;
               mant_o = MANT_MAXF;
            end
         end else begin
            exp_o  = exp_inc;
            mant_o = sum[MW+1:1];
         end
      end
   end

endmodule

// File: rtl/round_pipe.sv
// rtl/round_pipe.sv - two-stage pipelined IEEE-754 rounder with valid/ready on both sides
// Stage A captures the operand and round bit; stage B registers the rounded result.
module round_pipe
   import fpu_round_pkg::*;
#(
   parameter int MW = 23,
   parameter int EW = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sign,
   input  logic [EW-1:0] in_exp,
   input  logic [MW+1:0] in_mant,
   input  logic          in_sticky,
   input  logic [2:0]    in_rmode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_sign,
   output logic [EW-1:0] out_exp,
   output logic [MW:0]   out_mant,
   output logic          out_inexact,
   output logic          out_overflow
);

   logic          a_valid_q;
   logic          a_sign_q;
   logic [EW-1:0] a_exp_q;
   logic [MW:0]   a_mant_q;
   logic [2:0]    a_rm_q;
   logic          a_rnd_q;
   logic          a_inex_q;

   logic          b_valid_q;
   logic          b_sign_q;
   logic [EW-1:0] b_exp_q;
   logic [MW:0]   b_mant_q;
   logic          b_inex_q;
   logic          b_ovf_q;

   logic [EW-1:0] b_exp_d;
   logic [MW:0]   b_mant_d;
   logic          b_inex_d;
   logic          b_ovf_d;

   logic          ready_a;
   logic          ready_b;
   logic [2:0]    rm_in;
   logic          rnd_in;

   // Ready ripples back combinationally so a full pipe still streams at one beat per cycle.
   assign ready_b  = ~b_valid_q | out_ready;
   assign ready_a  = ~a_valid_q | ready_b;
   assign in_ready = ready_a;

   assign rm_in  = norm_rmode(in_rmode);
   assign rnd_in = rnd_bit(rm_in, in_sign, in_mant[1], in_mant[0], in_sticky);

   round_incr #(.MW(MW), .EW(EW)) u_incr (
      .sign_i     (a_sign_q),
      .exp_i      (a_exp_q),
      .mant_i     (a_mant_q),
      .rmode_i    (a_rm_q),
      .rnd_i      (a_rnd_q),
      .inexact_i  (a_inex_q),
      .exp_o      (b_exp_d),
      .mant_o     (b_mant_d),
      .inexact_o  (b_inex_d),
      .overflow_o (b_ovf_d)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         a_valid_q <= 1'b0;
         a_sign_q  <= 1'b0;
         a_exp_q   <= '0;
         a_mant_q  <= '0;
         a_rm_q    <= '0;
         a_rnd_q   <= 1'b0;
         a_inex_q  <= 1'b0;
         b_valid_q <= 1'b0;
         b_sign_q  <= 1'b0;
         b_exp_q   <= '0;
         b_mant_q  <= '0;
         b_inex_q  <= 1'b0;
         b_ovf_q   <= 1'b0;
      end else begin
         if (ready_a) begin
            a_valid_q <= in_valid;
            if (in_valid) begin
               a_sign_q <= in_sign;
               a_exp_q  <= in_exp;
               a_mant_q <= in_mant[MW+1:1];
               a_rm_q   <= rm_in;
               a_rnd_q  <= rnd_in;
               a_inex_q <= in_mant[0] | in_sticky;
            end
         end
         if (ready_b) begin
            b_valid_q <= a_valid_q;
            if (a_valid_q) begin
               b_sign_q <= a_sign_q;
               b_exp_q  <= b_exp_d;
               b_mant_q <= b_mant_d;
               b_inex_q <= b_inex_d;
               b_ovf_q  <= b_ovf_d;
            end
         end
      end
   end

   assign out_valid    = b_valid_q;
   assign out_sign     = b_sign_q;
   assign out_exp      = b_exp_q;
   assign out_mant     = b_mant_q;
   assign out_inexact  = b_inex_q;
   assign out_overflow = b_ovf_q;

endmodule

// File: tb/tb_round_pipe.sv
// tb/tb_round_pipe.sv - self-checking bench for round_pipe in binary32 and binary64 shapes
module tb_round_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_sign, in_sticky, out_ready;
   logic [10:0] in_exp;
   logic [53:0] in_mant;
   logic [2:0]  in_rmode;
   int          cfg = 0;

   logic        v0, v1;
   logic        r0_ready, r0_valid, r0_sign, r0_inex, r0_ovf;
   logic [7:0]  r0_exp;
   logic [23:0] r0_mant;
   logic        r1_ready, r1_valid, r1_sign, r1_inex, r1_ovf;
   logic [10:0] r1_exp;
   logic [52:0] r1_mant;

   logic        o_ready, o_valid, o_sign, o_inex, o_ovf;
   logic [10:0] o_exp;
   logic [52:0] o_mant;

   int vectors = 0;
   int errors  = 0;

   typedef struct packed {
      logic        sign;
      logic [10:0] exp;
      logic [52:0] mant;
      logic        inex;
      logic        ovf;
   } res_t;

   typedef struct packed {
      logic        s;
      logic [10:0] e;
      logic [53:0] m;
      logic        t;
      logic [2:0]  rm;
   } beat_t;

   assign v0 = in_valid & (cfg == 0);
   assign v1 = in_valid & (cfg == 1);

   round_pipe #(.MW(23), .EW(8)) u_sp (
      .CLK(clk), .RST(rst), .in_valid(v0), .in_ready(r0_ready), .in_sign(in_sign),
      .in_exp(in_exp[7:0]), .in_mant(in_mant[24:0]), .in_sticky(in_sticky),
      .in_rmode(in_rmode), .out_valid(r0_valid), .out_ready(out_ready), .out_sign(r0_sign),
      .out_exp(r0_exp), .out_mant(r0_mant), .out_inexact(r0_inex), .out_overflow(r0_ovf)
   );

   round_pipe #(.MW(52), .EW(11)) u_dp (
      .CLK(clk), .RST(rst), .in_valid(v1), .in_ready(r1_ready), .in_sign(in_sign),
      .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
      .in_rmode(in_rmode), .out_valid(r1_valid), .out_ready(out_ready), .out_sign(r1_sign),
      .out_exp(r1_exp), .out_mant(r1_mant), .out_inexact(r1_inex), .out_overflow(r1_ovf)
   );

   always_comb begin
      if (cfg == 0) begin
         o_ready = r0_ready; o_valid = r0_valid; o_sign = r0_sign;
         o_exp = {3'b0, r0_exp}; o_mant = {29'b0, r0_mant}; o_inex = r0_inex; o_ovf = r0_ovf;
      end else begin
         o_ready = r1_ready; o_valid = r1_valid; o_sign = r1_sign;
         o_exp = r1_exp; o_mant = r1_mant; o_inex = r1_inex; o_ovf = r1_ovf;
      end
   end

   function automatic int cur_mw();
      return (cfg == 0) ? 23 : 52;
   endfunction

   function automatic int cur_ew();
      return (cfg == 0) ? 8 : 11;
   endfunction

   function automatic res_t got();
      return {o_sign, o_exp, o_mant, o_inex, o_ovf};
   endfunction

   // Reference: rounding done on integer values straight from the mode rules.
   function automatic res_t model(beat_t b);
      res_t r;
      int mw, ew;
      longint unsigned eones, frac, sum;
      logic g, l, up;
      logic [2:0] rm;
      mw = cur_mw(); ew = cur_ew();
      eones = (64'd1 << ew) - 1;
      frac  = 64'(b.m) >> 1;
      g = b.m[0]; l = b.m[1];
      rm = (b.rm > 3'd4) ? 3'd0 : b.rm;
      r.sign = b.s;
      if (64'(b.e) == eones) begin
         r.exp = b.e; r.mant = 53'(frac); r.inex = 1'b0; r.ovf = 1'b0;
         return r;
      end
      case (rm)
         3'd0: up = g & (b.t | l);
         3'd1: up = 1'b0;
         3'd2: up = !b.s & (g | b.t);
         3'd3: up = b.s & (g | b.t);
         default: up = g;
      endcase
      sum = frac + 64'(up);
      r.inex = g | b.t; r.ovf = 1'b0; r.exp = b.e; r.mant = 53'(sum);
      if ((sum >> (mw + 1)) != 0) begin
         if (64'(b.e) + 1 == eones) begin
            r.ovf = 1'b1; r.inex = 1'b1;
            if (rm == 0 || rm == 4 || (rm == 2 && !b.s) || (rm == 3 && b.s)) begin
               r.exp = 11'(eones); r.mant = '0;
            end else begin
               r.exp = 11'(eones - 1); r.mant = 53'((64'd1 << (mw + 1)) - 1);
            end
         end else begin
            r.exp = b.e + 11'd1; r.mant = 53'(sum >> 1);
         end
      end
      return r;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      int mw, ew;
      logic [63:0] eo, m, mask;
      mw = cur_mw(); ew = cur_ew();
      eo = (64'd1 << ew) - 1;
      case ($urandom_range(0, 3))
         0: b.e = 11'(eo);
         1: b.e = 11'(eo - 1);
         2: b.e = 11'(eo - 2);
         default: b.e = 11'($urandom_range(1, 32'(eo) - 1));
      endcase
      mask = (64'd1 << (mw + 2)) - 1;
      m = {$urandom(), $urandom()} & mask;
      m = m | (64'd1 << (mw + 1));
      if ($urandom_range(0, 1) == 1) m = m | (((64'd1 << mw) - 1) << 1);
      b.m  = 54'(m);
      b.s  = 1'($urandom_range(0, 1));
      b.t  = 1'($urandom_range(0, 1));
      b.rm = 3'($urandom_range(0, 7));
      return b;
   endfunction

   task automatic drive(beat_t b);
      in_sign = b.s; in_exp = b.e; in_mant = b.m; in_sticky = b.t; in_rmode = b.rm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
      tick(); tick();
      vectors++;
      if (o_valid !== 1'b0 || got() !== '0) begin
         errors++;
         $display("FAIL reset_outputs cfg%0d: got valid=%b data=%h, expected valid=0 data=0", cfg, o_valid, got());
      end
      rst = 1'b0;
      vectors++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready cfg%0d: got %b expected 1", cfg, o_ready);
      end
   endtask

   task automatic test_directed();
      beat_t b[10];
      res_t  e[10];
      int mw, ew;
      logic [63:0] h, fmax, one, eo;
      mw = cur_mw(); ew = cur_ew();
      h = 64'd1 << (mw + 1); fmax = ((64'd1 << mw) - 1) << 1; one = 64'd1 << mw;
      eo = (64'd1 << ew) - 1;
      b[0] = {1'b0, 11'h80, 54'(h | 2 | 1), 1'b0, 3'd0};    e[0] = {1'b0, 11'h80, 53'(one | 2), 1'b1, 1'b0};
      b[1] = {1'b0, 11'h80, 54'(h | 1), 1'b0, 3'd0};        e[1] = {1'b0, 11'h80, 53'(one), 1'b1, 1'b0};
      b[2] = {1'b0, 11'h80, 54'(h | fmax | 1), 1'b0, 3'd2}; e[2] = {1'b0, 11'h81, 53'(one), 1'b1, 1'b0};
      b[3] = {1'b0, 11'(eo - 1), 54'(h | fmax | 1), 1'b0, 3'd0};
      e[3] = {1'b0, 11'(eo), 53'd0, 1'b1, 1'b1};
      b[4] = {1'b0, 11'(eo - 1), 54'(h | fmax | 1), 1'b0, 3'd1};
      e[4] = {1'b0, 11'(eo - 1), 53'((one << 1) - 1), 1'b1, 1'b0};
      b[5] = {1'b1, 11'(eo - 1), 54'(h | fmax | 1), 1'b0, 3'd3};
      e[5] = {1'b1, 11'(eo), 53'd0, 1'b1, 1'b1};
      b[6] = {1'b0, 11'(eo), 54'(h | 10 | 1), 1'b1, 3'd0};  e[6] = {1'b0, 11'(eo), 53'(one | 5), 1'b0, 1'b0};
      b[7] = {1'b0, 11'h80, 54'(h | 2 | 1), 1'b0, 3'd7};    e[7] = {1'b0, 11'h80, 53'(one | 2), 1'b1, 1'b0};
      b[8] = {1'b1, 11'h55, 54'(h | 2 | 1), 1'b1, 3'd1};    e[8] = {1'b1, 11'h55, 53'(one | 1), 1'b1, 1'b0};
      b[9] = {1'b0, 11'h33, 54'(h | 4), 1'b0, 3'd4};        e[9] = {1'b0, 11'h33, 53'(one | 2), 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(b[i]); in_valid = 1'b1; out_ready = 1'b1;
         vectors++;
         if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL dir_ready cfg%0d case%0d: got %b expected 1", cfg, i, o_ready);
         end
         tick();
         in_valid = 1'b0;
         vectors++;
         if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL dir_latency cfg%0d case%0d: out_valid %b one cycle after accept, expected 0", cfg, i, o_valid);
         end
         tick();
         vectors++;
         if (o_valid !== 1'b1 || got() !== e[i]) begin
            errors++;
            $display("FAIL dir_result cfg%0d case%0d: got valid=%b %h expected valid=1 %h", cfg, i, o_valid, got(), e[i]);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      beat_t bs[4];
      res_t  q[$];
      int sent, popped, cyc;
      sent = 0; popped = 0; cyc = 0;
      for (int i = 0; i < 4; i++) bs[i] = rand_beat();
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1; drive(bs[sent]);
         @(negedge clk);
         if (o_ready) begin q.push_back(model(bs[sent])); sent++; end
         tick();
      end
      vectors++;
      if (sent != 2 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_fill: accepted %0d beats in_ready=%b, expected 2 beats in_ready=0", sent, o_ready);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if (o_valid !== 1'b1 || got() !== q[0]) begin
            errors++;
            $display("FAIL bp_stall cyc%0d: got valid=%b %h expected valid=1 %h", c, o_valid, got(), q[0]);
         end
         tick();
      end
      out_ready = 1'b1;
      while ((sent < 4 || q.size() != 0) && cyc < 20) begin
         in_valid = (sent < 4);
         if (sent < 4) drive(bs[sent]);
         @(negedge clk);
         if (o_valid) begin
            vectors++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra: got beat %h expected none", got());
            end else begin
               if (got() !== q[0]) begin
                  errors++;
                  $display("FAIL bp_order beat%0d: got %h expected %h", popped, got(), q[0]);
               end
               void'(q.pop_front());
               popped++;
            end
         end
         if (in_valid && o_ready) begin q.push_back(model(bs[sent])); sent++; end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      vectors++;
      if (popped != 4) begin
         errors++;
         $display("FAIL bp_drain: got %0d beats out expected 4", popped);
      end
   endtask

   task automatic test_random(int nbeats);
      beat_t b;
      res_t  q[$];
      int sent, cyc;
      bit have;
      sent = 0; cyc = 0; have = 0;
      while ((sent < nbeats || q.size() != 0) && cyc < 4000) begin
         if (!have && sent < nbeats && $urandom_range(0, 3) != 0) begin
            b = rand_beat(); have = 1;
         end
         in_valid = have;
         if (have) drive(b);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (o_valid) begin
            vectors++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_spurious cfg%0d: got beat %h expected none", cfg, got());
            end else begin
               if (got() !== q[0]) begin
                  errors++;
                  $display("FAIL rand_result cfg%0d: got %h expected %h", cfg, got(), q[0]);
               end
               if (out_ready) void'(q.pop_front());
            end
         end
         if (have && o_ready) begin q.push_back(model(b)); have = 0; sent++; end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      vectors++;
      if (sent != nbeats || q.size() != 0) begin
         errors++;
         $display("FAIL rand_timeout cfg%0d: sent %0d pending %0d, expected sent %0d pending 0", cfg, sent, q.size(), nbeats);
      end
   endtask

   task automatic test_rst_midstream();
      out_ready = 1'b0;
      in_valid = 1'b1; drive(rand_beat()); tick();
      drive(rand_beat()); tick();
      in_valid = 1'b0;
      vectors++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_fill cfg%0d: got valid=%b ready=%b expected valid=1 ready=0", cfg, o_valid, o_ready);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      vectors++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || got() !== '0) begin
         errors++;
         $display("FAIL rst_flush cfg%0d: got valid=%b ready=%b data=%h expected 0/1/0", cfg, o_valid, o_ready, got());
      end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         vectors++;
         if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_ghost cfg%0d cyc%0d: got out_valid %b expected 0", cfg, c, o_valid);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_sign = 1'b0; in_exp = '0; in_mant = '0; in_sticky = 1'b0; in_rmode = '0;
      cfg = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_random(300);
      test_rst_midstream();
      cfg = 1;
      test_reset();
      test_directed();
      test_backpressure();
      test_random(300);
      test_rst_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
